// File: rtl/chargepump_monitor.sv
// chargepump_monitor: checks that a charge-pump pin toggles at the expected rate.
// Optional: define CHARGEPUMP_FAULT_COUNT_EN for the saturating fault counter.
module chargepump_monitor (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       cp_in,
  input  logic [7:0] period,
  input  logic [7:0] tolerance,
  input  logic       fault_clr,
  output logic       cp_ok,
  output logic       fault,
  output logic [8:0] measured,
  output logic [7:0] fault_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQUIRE,
    S_LOCKING,
    S_LOCKED,
    S_FAULT
  } state_e;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] meas_q, meas_d;
  logic [1:0] good_q, good_d;
  logic       cp_ok_q, cp_ok_d;
  logic       fault_q, fault_d;

  logic [9:0] nom, lo, hi, tol_x, cnt_x;
  logic       edge_det, good_edge, bad_edge;
  logic       timeout, cnt_sat;

  // Window bounds in 10 bits so P+1+T never wraps.
  always_comb begin
    tol_x = {2'b00, tolerance};
    nom   = {2'b00, period} + 10'd1;
    hi    = nom + tol_x;
    lo    = (nom > tol_x) ? (nom - tol_x) : 10'd0;
  end

  always_comb begin
    cnt_x     = {1'b0, cnt_q};
    cnt_sat   = &cnt_q;
    edge_det  = sync2_q ^ sync3_q;
    good_edge = edge_det && (cnt_x >= lo) && (cnt_x <= hi);
    bad_edge  = edge_det && !good_edge;
    timeout   = !edge_det && ((cnt_x > hi) || cnt_sat);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    meas_d  = meas_q;
    good_d  = good_q;

    if (state_q != S_IDLE) begin
      if (edge_det) begin
        cnt_d  = 9'd1;
        meas_d = cnt_q;
      end else if (!cnt_sat) begin
        cnt_d = cnt_q + 9'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        good_d  = '0;
        state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (edge_det) begin
          good_d  = '0;
          state_d = S_LOCKING;
        end
      end
      S_LOCKING: begin
        if (good_edge) begin
          if (good_q == 2'd3) begin
            good_d  = '0;
            state_d = S_LOCKED;
          end else begin
            good_d = good_q + 2'd1;
          end
        end else if (bad_edge) begin
          good_d = '0;
        end else if (timeout) begin
          good_d = '0;
          cnt_d  = '0;
        end
      end
      S_LOCKED: begin
        if (bad_edge || timeout) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_ACQUIRE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable wins over every other event, fault_clr included.
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      good_d  = '0;
    end

    cp_ok_d = (state_d == S_LOCKED);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      cnt_q   <= '0;
      meas_q  <= '0;
      good_q  <= '0;
      cp_ok_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= cp_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      cnt_q   <= cnt_d;
      meas_q  <= meas_d;
      good_q  <= good_d;
      cp_ok_q <= cp_ok_d;
      fault_q <= fault_d;
    end
  end

  assign cp_ok    = cp_ok_q;
  assign fault    = fault_q;
  assign measured = meas_q;

`ifdef CHARGEPUMP_FAULT_COUNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if ((state_q == S_LOCKED) && (state_d == S_FAULT)
        && (fcnt_q != 8'hff)) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign fault_count = fcnt_q;
`else
  assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_chargepump_monitor.sv
// tb_chargepump_monitor: directed vectors for chargepump_monitor.
// Expected values are hand-derived cycle counts from the pin toggles.
module tb_chargepump_monitor;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       cp_in = 1'b0;
  logic       fault_clr = 1'b0;
  logic [7:0] period = 8'd9;
  logic [7:0] tolerance = 8'd1;
  logic       cp_ok, fault;
  logic [8:0] measured;
  logic [7:0] fault_count;

  int errors = 0;
  int checks = 0;

`ifdef CHARGEPUMP_FAULT_COUNT_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  chargepump_monitor dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .cp_in(cp_in),
    .period(period),
    .tolerance(tolerance),
    .fault_clr(fault_clr),
    .cp_ok(cp_ok),
    .fault(fault),
    .measured(measured),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cp_run(input int n, input int sp);
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (i % sp == 0) cp_in = ~cp_in;
    end
  endtask

  // Edges 10 clocks apart: 1 discarded + 4 good, lock 43 clocks after first toggle.
  task automatic do_lock(input string tag);
    cp_in = ~cp_in;
    cp_run(40, 10);
    tick(2);
    chk({tag, "_pre"}, cp_ok, 0);
    tick(1);
    chk(tag, cp_ok, 1);
    chk({tag, "_meas"}, measured, 10);
  endtask

  task automatic clr_pulse();
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
  endtask

  task automatic fast_cycle();
    clr_pulse();
    cp_run(12, 1);
    tick(14);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_cp_ok", cp_ok, 0);
    chk("rst_fault", fault, 0);
    chk("rst_meas", measured, 0);
    chk("rst_fc", fault_count, 0);

    resetn = 1'b1;
    enable = 1'b1;
    tick(3);
    chk("acq_cp_ok", cp_ok, 0);

    do_lock("lock1");
    clr_pulse();
    chk("clr_ignored", cp_ok, 1);
    chk("clr_ign_fault", fault, 0);

    // One 13-clock interval while locked
    tick(9);
    cp_in = ~cp_in;
    tick(3);
    chk("i13_fault", fault, 1);
    chk("i13_cp_ok", cp_ok, 0);
    chk("i13_meas", measured, 13);
    chk("i13_fc", fault_count, FC ? 1 : 0);

    clr_pulse();
    do_lock("lock2");
    chk("lock2_fault", fault, 0);

    // Static pin: timeout when counter reaches 12
    tick(11);
    chk("static_pre_f", fault, 0);
    chk("static_pre_ok", cp_ok, 1);
    tick(1);
    chk("static_fault", fault, 1);
    chk("static_cp_ok", cp_ok, 0);
    chk("static_meas", measured, 10);
    tick(5);
    chk("fault_latch", fault, 1);
    chk("static_fc", fault_count, FC ? 2 : 0);

    // P=0, T=5: window [0,6], 1-clock toggles
    period = 8'd0;
    tolerance = 8'd5;
    clr_pulse();
    cp_run(20, 1);
    chk("fast_lock", cp_ok, 1);
    chk("fast_meas", measured, 1);
    tick(12);
    chk("fast_to_fault", fault, 1);
    chk("fast_fc", fault_count, FC ? 3 : 0);

    fault_clr = 1'b1;
    enable = 1'b0;
    tick(1);
    fault_clr = 1'b0;
    chk("dis_clr_fault", fault, 0);
    chk("dis_clr_cp_ok", cp_ok, 0);
    tick(3);
    chk("idle_fault", fault, 0);
    chk("idle_cp_ok", cp_ok, 0);

    period = 8'd9;
    tolerance = 8'd1;
    enable = 1'b1;
    tick(1);
    do_lock("lock3");

    // Asynchronous reset between clock edges
    #2 resetn = 1'b0;
    #1;
    chk("arst_cp_ok", cp_ok, 0);
    chk("arst_fault", fault, 0);
    chk("arst_meas", measured, 0);
    chk("arst_fc", fault_count, 0);
    #3 resetn = 1'b1;
    tick(1);
    do_lock("relock");

    // Window shrinks to H=6 while locked
    period = 8'd0;
    tolerance = 8'd5;
    tick(6);
    chk("newp_pre", fault, 0);
    tick(1);
    chk("newp_fault", fault, 1);
    chk("newp_fc", fault_count, FC ? 1 : 0);

`ifdef CHARGEPUMP_FAULT_COUNT_EN
    for (int i = 0; i < 99; i++) fast_cycle();
    chk("fc_100", fault_count, 100);
    for (int i = 0; i < 160; i++) fast_cycle();
    chk("fc_sat", fault_count, 255);
    chk("fc_sat_fault", fault, 1);
`else
    for (int i = 0; i < 3; i++) fast_cycle();
    chk("fc_tied", fault_count, 0);
    chk("fc_tied_fault", fault, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chargepump_monitor.md
CHARGEPUMP_MONITOR -- requirements
Module: chargepump_monitor

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-003 SHALL have port enable  input  1  monitor enable; low forces IDLE.
REQ-004 SHALL have port cp_in  input  1  charge-pump pin under test, asynchronous to clk.
REQ-005 SHALL have port period  input  8  expected half-period code P; nominal edge spacing is P+1 clocks.
REQ-006 SHALL have port tolerance  input  8  allowed deviation T in clocks.
REQ-007 SHALL have port fault_clr  input  1  single-cycle pulse that clears a latched fault.
REQ-008 SHALL have port cp_ok  output  1  high only in LOCKED.
REQ-009 SHALL have port fault  output  1  high only in FAULT.
REQ-010 SHALL have port measured  output  9  most recent edge-to-edge interval in clocks.
REQ-011 SHALL have port fault_count  output  8  saturating count of FAULT entries (see Configuration).

Function
REQ-012 SHALL synchronise cp_in through two flops, then register once more for edge detection; "edge" = either polarity change of the synchronised signal.
REQ-013 SHALL keep a 9-bit interval counter: on an edge cycle load 1, otherwise increment, saturating at 511.
REQ-014 SHALL, on an edge cycle, load measured with the counter value before reload.
REQ-015 SHALL compute nominal N = P+1, low bound L = max(N-T, 0), high bound H = N+T, using 10-bit arithmetic with no wrap.
REQ-016 SHALL classify an edge as good when L <= measured value <= H, otherwise bad.
REQ-017 SHALL flag timeout when the counter exceeds H with no edge; the saturated counter (511) SHALL also count as timeout.
REQ-018 SHALL implement states IDLE, ACQUIRE, LOCKING, LOCKED, FAULT.
REQ-019 IDLE: enable high -> ACQUIRE next cycle; counter held at 0.
REQ-020 ACQUIRE: first edge -> LOCKING, with its interval discarded; timeout -> remain.
REQ-021 LOCKING: 2-bit good-edge count; bad edge or timeout -> count cleared, counter restarted; 4th consecutive good edge -> LOCKED.
REQ-022 LOCKED: good edge -> remain; bad edge or timeout -> FAULT on the next cycle.
REQ-023 FAULT: latched; ignores cp_in classification; fault_clr -> ACQUIRE.
REQ-024 SHALL make enable low force IDLE from any state next cycle, overriding all other events, including fault_clr.
REQ-025 SHALL ignore fault_clr outside FAULT.
REQ-026 SHALL register cp_ok and fault directly from state, valid the cycle after the transition.
REQ-027 SHALL sample period/tolerance every cycle; a change while LOCKED takes effect at the next classification.

Reset
REQ-028 resetn low SHALL asynchronously set: state IDLE, cp_ok 0, fault 0, measured 0, counter 0, good count 0, synchroniser flops 0, fault_count 0.
REQ-029 Reset asserted mid-operation SHALL abandon any lock or fault; after release, the block SHALL resume from IDLE with no memory of prior state.

Configuration
REQ-030 With CHARGEPUMP_FAULT_COUNT_EN defined, fault_count SHALL increment on each LOCKED->FAULT transition, saturate at 255, and clear only by reset.
REQ-031 Without CHARGEPUMP_FAULT_COUNT_EN, fault_count SHALL be tied to 0 and no counter logic SHALL be synthesised; the port list SHALL be unchanged.

Verification
REQ-032 period=9, tolerance=1, cp_in toggling every 10 clocks -> measured=10; cp_ok rises the cycle after the 4th good edge following the discarded first edge.
REQ-033 Locked as in REQ-032, one interval of 13 -> fault=1, cp_ok=0 the cycle after that edge; fault_count=1 with macro, 0 without.
REQ-034 Locked as in REQ-032, cp_in held static -> counter reaches 12 (>H=11) -> FAULT entered; measured keeps 10.
REQ-035 period=0, tolerance=5 (L clamps to 0), 1-clock toggles -> locks; then fault_clr while enable drops in the same cycle -> IDLE, not ACQUIRE.
REQ-036 resetn pulsed low while LOCKED, asynchronously to clk -> all outputs 0 immediately; relock requires ACQUIRE plus 4 good edges.
REQ-037 With macro defined, 260 fault/clear/relock cycles -> fault_count saturates at 255.
